// File: rtl/exmod_rgba_blend555_pkg.sv
// Shared types, mode codes and decode helpers for the RGB555 blend stage.
package exmod_rgba_blend555_pkg;

    localparam int unsigned PIX_W = 16;
    localparam int unsigned CH_W  = 5;
    localparam int unsigned W_W   = 4;

    localparam logic [1:0] MODE_BLEND   = 2'd0;
    localparam logic [1:0] MODE_ADD     = 2'd1;
    localparam logic [1:0] MODE_REPLACE = 2'd2;
    localparam logic [1:0] MODE_RSVD    = 2'd3;

    localparam logic [W_W-1:0] W_OPAQUE = 4'd8;

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } rgb5_t;

    // Expand either pixel encoding to three 5-bit channels (nibbles replicate their MSB).
    function automatic rgb5_t expand_pix(input logic [PIX_W-1:0] pix);
        rgb5_t c;
        if (pix[15]) begin
            c.r = {pix[14:11], pix[14]};
            c.g = {pix[9:6],   pix[9]};
            c.b = {pix[4:1],   pix[4]};
        end else begin
            c.r = pix[14:10];
            c.g = pix[9:5];
            c.b = pix[4:0];
        end
        return c;
    endfunction

    // Map 3-bit alpha to a 0..8 weight so that full alpha is an exact 8/8.
    function automatic logic [W_W-1:0] alpha_weight(input logic [2:0] a3);
        return W_W'(a3) + W_W'(a3 >> 2);
    endfunction

endpackage

// File: rtl/exmod_rgba_lerp5.sv
// Single-channel combine: weighted blend, saturating add, or replace.
module exmod_rgba_lerp5
    import exmod_rgba_blend555_pkg::*;
(
    input  logic [CH_W-1:0] s,
    input  logic [CH_W-1:0] d,
    input  logic [W_W-1:0]  w,
    input  logic [1:0]      mode,
    output logic [CH_W-1:0] r
);

    logic [7:0] sw;
    logic [7:0] blend_sum;
    logic [5:0] add_sum;

    // Blend sum peaks at 31*8+4=252, so 8 bits never overflow.
    always_comb begin
        sw        = 8'(s) * 8'(w);
        blend_sum = sw + 8'(d) * 8'(W_OPAQUE - w) + 8'd4;
        add_sum   = 6'(d) + 6'(sw >> 3);
        r         = s;
        case (mode)
            MODE_BLEND:   r = CH_W'(blend_sum >> 3);
            MODE_ADD:     r = add_sum[5] ? 5'd31 : add_sum[4:0];
            MODE_REPLACE: r = s;
            MODE_RSVD:    r = s;
            default:      r = s;
        endcase
    end

endmodule

// File: rtl/exmod_rgba_blend555.sv
// Two-stage framebuffer blend pipeline with valid/ready flow control and write/skip counters.
module exmod_rgba_blend555
    import exmod_rgba_blend555_pkg::*;
#(
    parameter int unsigned TAG_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIX_W-1:0] in_src,
    input  logic [PIX_W-1:0] in_dst,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_pix,
    output logic             out_we,
    output logic [TAG_W-1:0] out_tag,
    input  logic             cnt_clear,
    output logic [CNT_W-1:0] cnt_wr,
    output logic [CNT_W-1:0] cnt_skip
);

    logic             s1_v;
    rgb5_t            s1_src;
    rgb5_t            s1_dst;
    logic [W_W-1:0]   s1_w;
    logic [1:0]       s1_mode;
    logic [TAG_W-1:0] s1_tag;

    rgb5_t            src_rgb;
    rgb5_t            dst_rgb;
    logic [W_W-1:0]   src_w;
    logic [CH_W-1:0]  res_r;
    logic [CH_W-1:0]  res_g;
    logic [CH_W-1:0]  res_b;
    logic             we_c;
    logic             s2_free;
    logic             adv2;
    logic             load1;
    logic             out_fire;

    // Flow control: stage 2 frees when empty or draining; stage 1 follows it.
    always_comb begin
        s2_free  = !out_valid || out_ready;
        adv2     = s1_v && s2_free;
        in_ready = !s1_v || s2_free;
        load1    = in_valid && in_ready;
        out_fire = out_valid && out_ready;
    end

    // Stage-1 decode of both pixels and the source weight.
    always_comb begin
        src_rgb = expand_pix(in_src);
        dst_rgb = expand_pix(in_dst);
        src_w   = in_src[15] ? alpha_weight({in_src[10], in_src[5], in_src[0]}) : W_OPAQUE;
    end

    // Stage-1 register: capture decoded input, drop valid when it moves on.
    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_v    <= 1'b0;
            s1_src  <= '0;
            s1_dst  <= '0;
            s1_w    <= '0;
            s1_mode <= '0;
            s1_tag  <= '0;
        end else if (load1) begin
            s1_v    <= 1'b1;
            s1_src  <= src_rgb;
            s1_dst  <= dst_rgb;
            s1_w    <= src_w;
            s1_mode <= in_mode;
            s1_tag  <= in_tag;
        end else if (adv2) begin
            s1_v    <= 1'b0;
        end
    end

    exmod_rgba_lerp5 u_lerp_r (.s(s1_src.r), .d(s1_dst.r), .w(s1_w), .mode(s1_mode), .r(res_r));
    exmod_rgba_lerp5 u_lerp_g (.s(s1_src.g), .d(s1_dst.g), .w(s1_w), .mode(s1_mode), .r(res_g));
    exmod_rgba_lerp5 u_lerp_b (.s(s1_src.b), .d(s1_dst.b), .w(s1_w), .mode(s1_mode), .r(res_b));

    // Zero weight in blend/add leaves the destination untouched, so the write is skipped.
    always_comb begin
        we_c = !(((s1_mode == MODE_BLEND) || (s1_mode == MODE_ADD)) && (s1_w == '0));
    end

    // Stage-2 output register: holds while the consumer stalls.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_pix   <= '0;
            out_we    <= 1'b0;
            out_tag   <= '0;
        end else if (s2_free) begin
            out_valid <= s1_v;
            if (s1_v) begin
                out_pix <= {1'b0, res_r, res_g, res_b};
                out_we  <= we_c;
                out_tag <= s1_tag;
            end
        end
    end

    // Delivered-result counters; clear takes priority over counting.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_wr   <= '0;
            cnt_skip <= '0;
        end else if (cnt_clear) begin
            cnt_wr   <= '0;
            cnt_skip <= '0;
        end else if (out_fire) begin
            if (out_we) begin
                cnt_wr   <= cnt_wr + CNT_W'(1);
            end else begin
                cnt_skip <= cnt_skip + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_exmod_rgba_blend555.sv
// Scoreboard bench for the RGB555 blend stage: directed cases plus randomized traffic.
module tb_exmod_rgba_blend555;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_src;
    logic [15:0] in_dst;
    logic [1:0]  in_mode;
    logic [31:0] in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pix;
    logic        out_we;
    logic [31:0] out_tag;
    logic        cnt_clear;
    logic [31:0] cnt_wr;
    logic [31:0] cnt_skip;

    typedef struct {
        logic [15:0] pix;
        logic        we;
        logic [31:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    bit          mon_on = 0;
    bit          bp_en = 0;
    logic [31:0] exp_wr = '0;
    logic [31:0] exp_skip = '0;

    exmod_rgba_blend555 dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src(in_src), .in_dst(in_dst), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pix(out_pix), .out_we(out_we), .out_tag(out_tag),
        .cnt_clear(cnt_clear), .cnt_wr(cnt_wr), .cnt_skip(cnt_skip)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    // Reference: decode channels and weight from the pixel rules with plain integers.
    function automatic int chan(input logic [15:0] p, input int c);
        int sh = 10 - 5 * c;
        int nib;
        if (p[15]) begin
            nib = int'((p >> (sh + 1)) & 16'hF);
            return nib * 2 + nib / 8;
        end
        return int'((p >> sh) & 16'h1F);
    endfunction

    function automatic exp_t ref_pix(input logic [15:0] src, input logic [15:0] dst,
                                     input logic [1:0] mode, input logic [31:0] tag);
        int wtab[8] = '{0, 1, 2, 3, 5, 6, 7, 8};
        int w;
        int s;
        int d;
        int r;
        int a3;
        exp_t e;
        a3 = int'(src[10]) * 4 + int'(src[5]) * 2 + int'(src[0]);
        w  = src[15] ? wtab[a3] : 8;
        e.pix = 16'h0;
        for (int c = 0; c < 3; c++) begin
            s = chan(src, c);
            d = chan(dst, c);
            if (mode == 2'd0)      r = (s * w + d * (8 - w) + 4) / 8;
            else if (mode == 2'd1) r = (d + (s * w) / 8 > 31) ? 31 : d + (s * w) / 8;
            else                   r = s;
            e.pix = e.pix | 16'(r << (10 - 5 * c));
        end
        e.we  = !((mode <= 2'd1) && (w == 0));
        e.tag = tag;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Present one pixel, wait (bounded) for acceptance, then log its expected result.
    task automatic send_px(input logic [15:0] src, input logic [15:0] dst,
                           input logic [1:0] mode, input logic [31:0] tag, input exp_t e);
        int waited = 0;
        in_valid = 1; in_src = src; in_dst = dst; in_mode = mode; in_tag = tag;
        forever begin
            @(negedge clock);
            if (in_ready) break;
            waited++;
            if (waited > 200) begin
                total++; bad++;
                $display("FAIL accept_timeout tag=%h", tag);
                break;
            end
        end
        if (waited <= 200) sb.push_back(e);
        @(posedge clock); #1;
        in_valid = 0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: pop and compare on every delivered result; track expected counters.
    always @(negedge clock) begin
        exp_t e;
        bit   hs;
        if (mon_on) begin
            check("cnt_wr", cnt_wr, exp_wr);
            check("cnt_skip", cnt_skip, exp_skip);
            hs = reset && out_valid && out_ready;
            if (hs) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_out got tag=%h want none", out_tag);
                end else begin
                    e = sb.pop_front();
                    check("out_pix", 32'(out_pix), 32'(e.pix));
                    check("out_we", 32'(out_we), 32'(e.we));
                    check("out_tag", out_tag, e.tag);
                end
            end
            if (!reset || cnt_clear) begin
                exp_wr = '0; exp_skip = '0;
            end else if (hs) begin
                if (out_we) exp_wr = exp_wr + 1;
                else        exp_skip = exp_skip + 1;
            end
        end
    end

    // Random backpressure and occasional counter clears during the random phase.
    always @(posedge clock) begin
        #1;
        if (bp_en) begin
            out_ready = ($urandom_range(0, 3) != 0);
            cnt_clear = ($urandom_range(0, 31) == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] rs;
        logic [15:0] rd;
        logic [1:0]  rm;
        reset = 0; in_valid = 0; in_src = 0; in_dst = 0; in_mode = 0; in_tag = 0;
        out_ready = 1; cnt_clear = 0;
        repeat (3) @(posedge clock);
        #1;
        mon_on = 1;
        @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_pix", 32'(out_pix), 32'd0);
        check("rst_out_we", 32'(out_we), 32'd0);
        check("rst_out_tag", out_tag, 32'd0);
        @(posedge clock); #1;
        reset = 1;
        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;

        // 1: opaque white over black, with 2-clock latency
        e.pix = 16'h7FFF; e.we = 1; e.tag = 32'h1;
        send_px(16'h7FFF, 16'h0000, 2'd0, 32'h1, e);
        @(negedge clock);
        check("lat1_out_valid", 32'(out_valid), 32'd0);
        @(negedge clock);
        check("lat2_out_valid", 32'(out_valid), 32'd1);
        drain("drain1");

        // 2: alpha source with weight 3
        e.pix = 16'h3000; e.we = 1; e.tag = 32'h2;
        @(posedge clock); #1;
        send_px(16'hF821, 16'h0000, 2'd0, 32'h2, e);
        drain("drain2");

        // 3: fully transparent blend skips the write
        e.pix = 16'h1234; e.we = 0; e.tag = 32'h3;
        @(posedge clock); #1;
        send_px(16'h8000, 16'h1234, 2'd0, 32'h3, e);
        drain("drain3");
        @(negedge clock);
        check("t3_cnt_skip", cnt_skip, 32'd1);
        check("t3_cnt_wr", cnt_wr, 32'd2);

        // 4: additive saturation on red
        e.pix = 16'h7C00; e.we = 1; e.tag = 32'h4;
        @(posedge clock); #1;
        send_px(16'h7C00, 16'h7C00, 2'd1, 32'h4, e);
        drain("drain4");

        // 5: backpressure with four replace pixels
        @(posedge clock); #1;
        out_ready = 0;
        fork
            begin
                for (int k = 0; k < 4; k++) begin
                    e.pix = 16'(16'h0421 * (k + 1)); e.we = 1; e.tag = 32'h100 + 32'(k);
                    send_px(16'(16'h0421 * (k + 1)), 16'h5555, 2'(2 + (k % 2)), 32'h100 + 32'(k), e);
                end
            end
            begin
                repeat (2) @(negedge clock);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clock);
                    check("bp_in_ready", 32'(in_ready), 32'd0);
                    check("bp_out_valid", 32'(out_valid), 32'd1);
                    check("bp_out_tag", out_tag, 32'h100);
                    check("bp_out_pix", 32'(out_pix), 32'h0421);
                end
                @(posedge clock); #1;
                out_ready = 1;
            end
        join
        drain("drain5");

        // 6: reset with both stages full, then clear coincident with a handshake
        @(posedge clock); #1;
        out_ready = 0;
        e.pix = 16'h7FFF; e.we = 1; e.tag = 32'h200;
        send_px(16'h7FFF, 16'h0, 2'd2, 32'h200, e);
        e.tag = 32'h201;
        send_px(16'h7FFF, 16'h0, 2'd2, 32'h201, e);
        reset = 0;
        @(posedge clock); #1;
        reset = 1;
        sb.delete();
        @(negedge clock);
        check("r6_out_valid", 32'(out_valid), 32'd0);
        check("r6_cnt_wr", cnt_wr, 32'd0);
        check("r6_cnt_skip", cnt_skip, 32'd0);
        check("r6_in_ready", 32'(in_ready), 32'd1);
        @(posedge clock); #1;
        out_ready = 1;
        e.pix = 16'h7FFF; e.we = 1; e.tag = 32'h300;
        send_px(16'h7FFF, 16'h0, 2'd0, 32'h300, e);
        @(posedge clock); #1;
        cnt_clear = 1;
        @(posedge clock); #1;
        cnt_clear = 0;
        @(negedge clock);
        check("clr_cnt_wr", cnt_wr, 32'd0);
        drain("drain6");

        // Random traffic against the reference model
        @(posedge clock); #1;
        bp_en = 1;
        for (int i = 0; i < 300; i++) begin
            rs = 16'($urandom);
            rd = 16'($urandom);
            rm = 2'($urandom_range(0, 3));
            send_px(rs, rd, rm, 32'h1000 + 32'(i), ref_pix(rs, rd, rm, 32'h1000 + 32'(i)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock); #1;
            end
        end
        bp_en = 0;
        @(posedge clock); #1;
        out_ready = 1; cnt_clear = 0;
        drain("drain_rand");
        repeat (3) @(negedge clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
